// File: rtl/updown_mod_counter.sv
// Up/down counter with a runtime modulus, parallel load and wrap/saturate/one-shot terminal modes.
// Optional build macro PRESCALE_EN inserts a PRESCALE-cycle prescaler ahead of each count step.
module updown_mod_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             zero
);

    typedef enum logic {RUN, EXPIRED} state_t;

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    state_t           state;
    logic             step;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] rst_clamped;

    assign term         = up_dn ? max_val : '0;
    assign load_clamped = (load_val > max_val) ? max_val : load_val;
    assign rst_clamped  = (RST_VAL > max_val) ? max_val : RST_VAL;
    assign zero         = (count == '0);

`ifdef PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps;

    assign step = en && (ps == PS_LAST);

    // Prescaler advances on every enabled cycle, even while expired.
    always_ff @(posedge clk) begin
        if (reset || load)
            ps <= '0;
        else if (en)
            ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
`else
    // Without the prescaler every enabled cycle is a step.
    assign step = en && (PRESCALE >= 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= rst_clamped;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= RUN;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= RUN;
        end else begin
            tc <= 1'b0;
            if (step && state == RUN) begin
                // A count left above a lowered max_val is pulled back without a terminal event.
                if (count > max_val) begin
                    count <= up_dn ? max_val : count - WIDTH'(1);
                end else if (count == term) begin
                    tc <= 1'b1;
                    case (mode)
                        2'b01: ;
                        2'b10: begin
                            done  <= 1'b1;
                            state <= EXPIRED;
                        end
                        default: count <= up_dn ? '0 : max_val;
                    endcase
                end else begin
                    count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed plus random stimulus for updown_mod_counter, checked against an arithmetic reference model.
module tb_updown_mod_counter;

    localparam int WIDTH     = 4;
    localparam int RESET_VAL = 3;
    localparam int PRESCALE  = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             zero;

    int checks = 0;
    int errors = 0;

    int m_cnt  = 0;
    int m_tc   = 0;
    int m_done = 0;
    int m_ps   = 0;
    int tcs;

    updown_mod_counter #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .max_val (max_val),
        .mode    (mode),
        .count   (count),
        .tc      (tc),
        .done    (done),
        .zero    (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the counting rules.
    task automatic model_edge();
        int  mv;
        int  lv;
        bit  stp;
        mv = int'(max_val);
        lv = int'(load_val);
        if (reset) begin
            m_cnt  = (RESET_VAL > mv) ? mv : RESET_VAL;
            m_tc   = 0;
            m_done = 0;
            m_ps   = 0;
        end else if (load) begin
            m_cnt  = (lv > mv) ? mv : lv;
            m_tc   = 0;
            m_done = 0;
            m_ps   = 0;
        end else if (en) begin
            stp = 1'b1;
`ifdef PRESCALE_EN
            stp  = (m_ps == PRESCALE - 1);
            m_ps = stp ? 0 : m_ps + 1;
`endif
            m_tc = 0;
            if (stp && m_done == 0) begin
                if (m_cnt > mv) begin
                    m_cnt = up_dn ? mv : m_cnt - 1;
                end else if ((up_dn && m_cnt == mv) || (!up_dn && m_cnt == 0)) begin
                    m_tc = 1;
                    if (mode == 2'b10)
                        m_done = 1;
                    else if (mode != 2'b01)
                        m_cnt = up_dn ? 0 : mv;
                end else begin
                    m_cnt = up_dn ? m_cnt + 1 : m_cnt - 1;
                end
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "/count"}, 32'(count), 32'(m_cnt));
        chk({tag, "/tc"},    32'(tc),    32'(m_tc));
        chk({tag, "/done"},  32'(done),  32'(m_done));
        chk({tag, "/zero"},  32'(zero),  32'(m_cnt == 0));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0;
        load_val = '0; max_val = 4'd9; mode = 2'b00;
        cyc("reset");
        chk("reset_value", 32'(count), 32'(RESET_VAL));

        // Wrap down from 0 with max_val 9.
        reset = 1'b0; load = 1'b1; load_val = 4'd0;
        cyc("load0");
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tcs = 0;
        repeat (11) begin
            cyc("wrap_dn");
            tcs += int'(tc);
        end
`ifndef PRESCALE_EN
        chk("wrap_dn_tc_pulses", 32'(tcs), 32'd2);
        chk("wrap_dn_end", 32'(count), 32'd9);
`endif

        // Saturate up from 7.
        load = 1'b1; load_val = 4'd7; mode = 2'b01; up_dn = 1'b1;
        cyc("sat_load");
        load = 1'b0;
        repeat (5) cyc("sat_up");
`ifndef PRESCALE_EN
        chk("sat_hold", 32'(count), 32'd9);
`endif

        // One-shot down from 3, then reload.
        load = 1'b1; load_val = 4'd3; mode = 2'b10; up_dn = 1'b0;
        cyc("os_load");
        load = 1'b0;
        repeat (6) cyc("os_dn");
`ifndef PRESCALE_EN
        chk("os_done", 32'(done), 32'd1);
        chk("os_frozen", 32'(count), 32'd0);
`endif
        mode = 2'b00;
        repeat (2) cyc("os_expired_wrap");
        load = 1'b1; load_val = 4'd5; mode = 2'b10;
        cyc("os_reload");
        chk("os_reload_done", 32'(done), 32'd0);
        load = 1'b0;
        repeat (2) cyc("os_resume");

        // Load clamp beats en; reset beats load.
        max_val = 4'd6; load_val = 4'd12; load = 1'b1; en = 1'b1;
        cyc("load_clamp");
        chk("load_clamp_val", 32'(count), 32'd6);
        reset = 1'b1;
        cyc("rst_over_load");
        chk("rst_over_load_val", 32'(count), 32'(RESET_VAL));
        reset = 1'b0;

        // max_val 0: every enabled step is terminal.
        max_val = 4'd0; load_val = 4'd5; mode = 2'b00;
        cyc("mv0_load");
        load = 1'b0;
        tcs = 0;
        repeat (4) begin
            cyc("mv0_run");
            tcs += int'(tc);
        end
`ifndef PRESCALE_EN
        chk("mv0_tc_every", 32'(tcs), 32'd4);
`endif

        // Direction flips at 5.
        max_val = 4'd9; load = 1'b1; load_val = 4'd5; up_dn = 1'b0;
        cyc("flip_load_a");
        load = 1'b0; up_dn = 1'b1;
        repeat (4) cyc("flip_up");
        load = 1'b1; load_val = 4'd5;
        cyc("flip_load_b");
        load = 1'b0; up_dn = 1'b0;
        repeat (4) cyc("flip_dn");

        // Lowered max_val while counting.
        load = 1'b1; load_val = 4'd8; max_val = 4'd9;
        cyc("lower_load");
        load = 1'b0; max_val = 4'd4; up_dn = 1'b1;
        repeat (3) cyc("lower_up");

        // Randomised traffic.
        repeat (500) begin
            reset    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) max_val = 4'($urandom);
            load_val = 4'($urandom);
            cyc("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised synchronous up/down counter with a runtime modulus, parallel load, and three terminal modes: wrap, saturate, one-shot.
It is the general counting primitive for timers, countdown displays and frequency dividers, and replaces fixed 4-bit single-direction counters.
It produces a registered terminal-count pulse and a sticky done flag for control FSMs.

Parameters:
WIDTH, 8, counter width in bits (2..32)
RESET_VAL, 0, value of count after reset (must be <= 2**WIDTH-1)
PRESCALE, 4, enabled cycles per count step; used only when PRESCALE_EN is defined (>= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
max_val  input  WIDTH  runtime upper bound; count range is 0..max_val
mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as 00
count  output  WIDTH  current count (registered)
tc  output  1  registered terminal-count pulse
done  output  1  sticky one-shot expiry flag
zero  output  1  combinational, count == 0

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: count = RESET_VAL clamped to max_val; tc = 0; done = 0; FSM = RUN.
- Priority per edge: reset > load > en. With none asserted, count holds and tc = 0.
- Load:
  - count <= min(load_val, max_val); done <= 0; FSM <= RUN; tc <= 0. The en input is ignored that cycle.
- Terminal value: max_val when up_dn = 1; 0 when up_dn = 0. up_dn is sampled every edge, so a direction change applies at the next enabled step.
- Enabled step (en = 1, no load, FSM = RUN):
  - count != terminal: count ± 1 (modulo 2**WIDTH never reached, because range is clamped); tc <= 0.
  - count == terminal, wrap: up goes max_val -> 0, down goes 0 -> max_val; tc <= 1.
  - count == terminal, saturate: count holds; tc <= 1 on every such enabled cycle.
  - count == terminal, one-shot: count holds; tc <= 1; done <= 1; FSM <= EXPIRED.
- FSM states: RUN, EXPIRED.
  - EXPIRED: count frozen, tc = 0, done = 1.
  - Exit only by load (-> RUN) or reset.
  - If mode changes to wrap or saturate while EXPIRED, the FSM stays EXPIRED until load.
- tc is exactly one cycle per terminal event, visible the cycle after the triggering edge.
- max_val lowered below the current count: on the next enabled step, count <= max_val (up) or count - 1 (down). The clamp applies before the step and produces no tc.
- max_val = 0: count stays 0. Every enabled cycle is a terminal event; wrap and saturate pulse tc each cycle.
- reset asserted mid-count or in EXPIRED: takes effect at that edge, overriding load and en.
- zero is combinational from count only, with no added latency.

Optional Feature:
PRESCALE_EN:
- Defined:
  - A prescaler counter (width clog2(PRESCALE)) counts enabled cycles. A count step and its terminal evaluation happen only on the enabled cycle where the prescaler = PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler is cleared by reset and by load, and holds while en = 0.
  - tc still pulses for one clk cycle.
- Undefined: no prescaler logic; every enabled cycle is a step. This is identical to PRESCALE = 1.

Test Plan:
- Reset/wrap down (WIDTH = 4): reset 1 cycle, then load 0 with max_val = 9, mode = 00, up_dn = 0, en = 1 -> count 9,8,...,0,9; tc = 1 for exactly one cycle after the 0->9 step; zero = 1 while count = 0.
- Saturate up: load 7, max_val = 9, mode = 01, up_dn = 1, en held 5 cycles -> count 8,9,9,9,9; tc high on each cycle after an edge at 9.
- One-shot: load 3, mode = 10, up_dn = 0, en = 1 -> 2,1,0 then done = 1 and count frozen at 0 despite en; load 5 -> done = 0 and counting resumes 4,3...
- Load clamp and priority: max_val = 6, load_val = 12 with load = en = 1 -> count = 6, tc = 0. Assert reset with load = 1 -> count = RESET_VAL, done = 0.
- Boundary: max_val = 0, mode = 00, en = 1 -> count stays 0 and tc pulses every cycle. Direction flip at count = 5 mid-run -> next step is 4 (down) or 6 (up) with no tc.
- PRESCALE_EN defined, PRESCALE = 4: en = 1 continuously, wrap up from 0, max_val = 2 -> count changes every 4th cycle (0,1,2,0); load mid-prescale restarts the 4-cycle spacing.
